// File: rtl/player_motion.sv
// Frame-rate player physics: requests a collision scan each frame, applies motion and gravity,
// then releases the checker. Optional airborne extra jump is enabled by defining DOUBLE_JUMP_EN.
module player_motion #(
  parameter int WIDTH    = 10,
  parameter int HEIGHT   = 20,
  parameter int H_SPEED  = 2,
  parameter int GRAVITY  = 1,
  parameter int JUMP_V   = 8,
  parameter int MAX_FALL = 8,
  parameter int X_INIT   = 100,
  parameter int Y_INIT   = 100,
  parameter int SCREEN_W = 640,
  parameter int SCREEN_H = 480
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        frame_tick,
  input  logic        btn_left,
  input  logic        btn_right,
  input  logic        btn_jump,
  output logic        coll_start,
  output logic        coll_redo,
  input  logic        coll_done,
  input  logic        coll_up,
  input  logic        coll_down,
  input  logic        coll_left,
  input  logic        coll_right,
  input  logic [43:0] coll_object,
  output logic [9:0]  x,
  output logic [8:0]  y,
  output logic        grounded,
  output logic        overrun
);

  typedef enum logic [2:0] {
    S_FLUSH,
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_APPLY,
    S_RELEASE
  } state_t;

  localparam logic signed [11:0] C_W     = 12'(WIDTH);
  localparam logic signed [11:0] C_H     = 12'(HEIGHT);
  localparam logic signed [11:0] C_HS    = 12'(H_SPEED);
  localparam logic signed [11:0] C_G     = 12'(GRAVITY);
  localparam logic signed [11:0] C_MF    = 12'(MAX_FALL);
  localparam logic signed [11:0] C_X_MAX = 12'(SCREEN_W - WIDTH - 1);
  localparam logic signed [11:0] C_Y_MAX = 12'(SCREEN_H - HEIGHT - 1);
  localparam logic signed [5:0]  C_JUMP  = 6'(-JUMP_V);

  state_t             r_state;
  logic               r_coll_start;
  logic               r_coll_redo;
  logic               r_overrun;
  logic [9:0]         r_x;
  logic [8:0]         r_y;
  logic               r_grounded;
  logic [9:0]         r_px;
  logic [8:0]         r_py;
  logic signed [5:0]  r_vy;
  logic               r_g;
  logic               r_up;
  logic               r_down;
  logic               r_left;
  logic               r_right;
  logic [43:0]        r_obj;
`ifdef DOUBLE_JUMP_EN
  logic               r_jump_prev;
  logic               r_dj_armed;
  logic               w_dj_armed_new;
`endif

  logic [10:0]        w_obj_lx;
  logic [10:0]        w_obj_ty;
  logic [10:0]        w_obj_rx;
  logic [10:0]        w_obj_by;
  logic signed [11:0] w_dx;
  logic signed [11:0] w_x_raw;
  logic [9:0]         w_x_new;
  logic signed [11:0] w_vy_ext;
  logic signed [11:0] w_vy_sum;
  logic signed [11:0] w_y_raw;
  logic [8:0]         w_y_new;
  logic signed [5:0]  w_vy_new;
  logic               w_g_new;

  assign w_obj_lx = r_obj[43:33];
  assign w_obj_ty = r_obj[32:22];
  assign w_obj_rx = r_obj[21:11];
  assign w_obj_by = r_obj[10:0];
  assign w_vy_ext = {{6{r_vy[5]}}, r_vy};
  assign w_vy_sum = w_vy_ext + C_G;

  // Horizontal: wall snap takes priority over free motion, then clamp to the screen.
  always_comb begin
    w_dx = '0;
    if (btn_right && !btn_left) begin
      w_dx = C_HS;
    end else if (btn_left && !btn_right) begin
      w_dx = -C_HS;
    end

    if (w_dx > 12'sd0 && r_right) begin
      w_x_raw = $signed({1'b0, w_obj_lx}) - C_W - 12'sd1;
    end else if (w_dx < 12'sd0 && r_left) begin
      w_x_raw = $signed({1'b0, w_obj_rx}) + 12'sd1;
    end else begin
      w_x_raw = $signed({2'b00, r_px}) + w_dx;
    end

    if (w_x_raw < 12'sd0) begin
      w_x_new = '0;
    end else if (w_x_raw > C_X_MAX) begin
      w_x_new = C_X_MAX[9:0];
    end else begin
      w_x_new = w_x_raw[9:0];
    end
  end

  // Vertical: floor/ceiling contact, gravity with terminal velocity, screen clamp, then jump.
  always_comb begin
    w_y_raw  = $signed({3'b000, r_py});
    w_vy_new = r_vy;
    w_g_new  = 1'b0;
`ifdef DOUBLE_JUMP_EN
    w_dj_armed_new = r_dj_armed;
`endif

    if (r_down && !r_vy[5]) begin
      w_y_raw  = $signed({1'b0, w_obj_ty}) - C_H - 12'sd1;
      w_vy_new = '0;
      w_g_new  = 1'b1;
    end else if (r_up && r_vy[5]) begin
      w_y_raw  = $signed({1'b0, w_obj_by}) + 12'sd1;
      w_vy_new = '0;
    end else begin
      w_y_raw  = $signed({3'b000, r_py}) + w_vy_ext;
      w_vy_new = (w_vy_sum > C_MF) ? C_MF[5:0] : w_vy_sum[5:0];
    end

    if (w_y_raw >= C_Y_MAX) begin
      w_y_new  = C_Y_MAX[8:0];
      w_vy_new = '0;
      w_g_new  = 1'b1;
    end else if (w_y_raw < 12'sd0) begin
      w_y_new  = '0;
      w_vy_new = '0;
    end else begin
      w_y_new = w_y_raw[8:0];
    end

    if (w_g_new && btn_jump) begin
      w_vy_new = C_JUMP;
    end
`ifdef DOUBLE_JUMP_EN
    if (w_g_new) begin
      w_dj_armed_new = 1'b1;
    end else if (r_dj_armed && btn_jump && !r_jump_prev) begin
      w_vy_new       = C_JUMP;
      w_dj_armed_new = 1'b0;
    end
`endif
  end

  // Pulses are registered on the transition, so coll_redo appears in the cycle after FLUSH/RELEASE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_FLUSH;
      r_coll_start <= 1'b0;
      r_coll_redo  <= 1'b0;
      r_overrun    <= 1'b0;
      r_x          <= 10'(X_INIT);
      r_y          <= 9'(Y_INIT);
      r_grounded   <= 1'b0;
      r_px         <= 10'(X_INIT);
      r_py         <= 9'(Y_INIT);
      r_vy         <= '0;
      r_g          <= 1'b0;
      r_up         <= 1'b0;
      r_down       <= 1'b0;
      r_left       <= 1'b0;
      r_right      <= 1'b0;
      r_obj        <= '0;
`ifdef DOUBLE_JUMP_EN
      r_jump_prev  <= 1'b0;
      r_dj_armed   <= 1'b1;
`endif
    end else begin
      r_coll_start <= 1'b0;
      r_coll_redo  <= 1'b0;
      if (frame_tick && r_state != S_IDLE) begin
        r_overrun <= 1'b1;
      end
      case (r_state)
        S_FLUSH: begin
          r_coll_redo <= 1'b1;
          r_state     <= S_IDLE;
        end
        S_IDLE: begin
          if (frame_tick) begin
            r_coll_start <= 1'b1;
            r_state      <= S_REQ;
          end
        end
        S_REQ: begin
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (coll_done) begin
            r_up    <= coll_up;
            r_down  <= coll_down;
            r_left  <= coll_left;
            r_right <= coll_right;
            r_obj   <= coll_object;
            r_state <= S_APPLY;
          end
        end
        S_APPLY: begin
          r_px    <= w_x_new;
          r_py    <= w_y_new;
          r_vy    <= w_vy_new;
          r_g     <= w_g_new;
`ifdef DOUBLE_JUMP_EN
          r_jump_prev <= btn_jump;
          r_dj_armed  <= w_dj_armed_new;
`endif
          r_state <= S_RELEASE;
        end
        S_RELEASE: begin
          r_x         <= r_px;
          r_y         <= r_py;
          r_grounded  <= r_g;
          r_coll_redo <= 1'b1;
          r_state     <= S_IDLE;
        end
        default: begin
          r_state <= S_FLUSH;
        end
      endcase
    end
  end

  assign coll_start = r_coll_start;
  assign coll_redo  = r_coll_redo;
  assign x          = r_x;
  assign y          = r_y;
  assign grounded   = r_grounded;
  assign overrun    = r_overrun;

endmodule

// File: tb/tb_player_motion.sv
// Directed bench for player_motion: acts as the collision checker and compares
// published position/flags against hand-computed values for each frame.
module tb_player_motion;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        frame_tick = 1'b0;
  logic        btn_left = 1'b0;
  logic        btn_right = 1'b0;
  logic        btn_jump = 1'b0;
  logic        coll_start;
  logic        coll_redo;
  logic        coll_done = 1'b0;
  logic        coll_up = 1'b0;
  logic        coll_down = 1'b0;
  logic        coll_left = 1'b0;
  logic        coll_right = 1'b0;
  logic [43:0] coll_object = '0;
  logic [9:0]  x;
  logic [8:0]  y;
  logic        grounded;
  logic        overrun;

  int n_cmp = 0;
  int n_bad = 0;
  int n_start = 0;
  int n_redo = 0;

  player_motion dut (
    .clk         (clk),
    .reset       (reset),
    .frame_tick  (frame_tick),
    .btn_left    (btn_left),
    .btn_right   (btn_right),
    .btn_jump    (btn_jump),
    .coll_start  (coll_start),
    .coll_redo   (coll_redo),
    .coll_done   (coll_done),
    .coll_up     (coll_up),
    .coll_down   (coll_down),
    .coll_left   (coll_left),
    .coll_right  (coll_right),
    .coll_object (coll_object),
    .x           (x),
    .y           (y),
    .grounded    (grounded),
    .overrun     (overrun)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (coll_start === 1'b1) n_start++;
    if (coll_redo === 1'b1) n_redo++;
  end

  task automatic check(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end else begin
      $display("ok   %s: %0d", tag, obs);
    end
  endtask

  // Wait (bounded) for coll_start after issuing a tick; returns 1 if seen.
  task automatic tick_and_wait_start(output bit seen);
    @(posedge clk); #1 frame_tick = 1'b1;
    @(posedge clk); #1 frame_tick = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (coll_start === 1'b1) seen = 1'b1;
    end
  endtask

  // Answer the scan with the given flags; returns negedges from coll_done to coll_redo.
  task automatic answer_scan(input logic cu, cd, cl, cr, input int lx, ty, rx, by, output int lat);
    bit seen;
    @(posedge clk); #1;
    coll_up = cu; coll_down = cd; coll_left = cl; coll_right = cr;
    coll_object = {11'(lx), 11'(ty), 11'(rx), 11'(by)};
    coll_done = 1'b1;
    seen = 1'b0;
    lat = -1;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (coll_redo === 1'b1) begin
        seen = 1'b1;
        lat = i;
      end
    end
    @(posedge clk); #1;
    coll_done = 1'b0;
    coll_up = 1'b0; coll_down = 1'b0; coll_left = 1'b0; coll_right = 1'b0;
  endtask

  task automatic run_frame(input string tag, input logic l, r, j, cu, cd, cl, cr,
                           input int lx, ty, rx, by, input int ex, ey, eg);
    int s0, r0, lat;
    bit seen;
    btn_left = l; btn_right = r; btn_jump = j;
    s0 = n_start;
    r0 = n_redo;
    tick_and_wait_start(seen);
    check({tag, ":start_seen"}, int'(seen), 1);
    answer_scan(cu, cd, cl, cr, lx, ty, rx, by, lat);
    check({tag, ":latency"}, lat, 3);
    check({tag, ":x"}, int'(x), ex);
    check({tag, ":y"}, int'(y), ey);
    check({tag, ":grounded"}, int'(grounded), eg);
    repeat (2) @(posedge clk);
    #1;
    check({tag, ":starts"}, n_start - s0, 1);
    check({tag, ":redos"}, n_redo - r0, 1);
  endtask

  initial begin
    int s0, r0, lat;
    bit seen;

    #2 reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst:x", int'(x), 100);
    check("rst:y", int'(y), 100);
    check("rst:coll_start", int'(coll_start), 0);
    check("rst:coll_redo", int'(coll_redo), 0);
    check("rst:grounded", int'(grounded), 0);
    check("rst:overrun", int'(overrun), 0);
    r0 = n_redo;
    reset = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("flush:redo_pulses", n_redo - r0, 1);
    check("flush:coll_start", int'(coll_start), 0);

    //        tag            l  r  j  cu cd cl cr  lx   ty   rx  by   x    y    g
    run_frame("fall1",       0, 0, 0, 0, 0, 0, 0,  0,   0,   0,  0,   100, 100, 0);
    run_frame("fall2",       0, 0, 0, 0, 0, 0, 0,  0,   0,   0,  0,   100, 101, 0);
    run_frame("fall3",       0, 0, 0, 0, 0, 0, 0,  0,   0,   0,  0,   100, 103, 0);
    run_frame("fall4",       0, 0, 0, 0, 0, 0, 0,  0,   0,   0,  0,   100, 106, 0);
    run_frame("land",        0, 0, 0, 0, 1, 0, 0,  0,   200, 0,  0,   100, 179, 1);
    run_frame("wall_r_jump", 0, 1, 1, 0, 1, 0, 1,  300, 200, 0,  0,   289, 179, 1);
    run_frame("wall_l",      1, 0, 0, 0, 0, 0, 1,  300, 0,   0,  0,   287, 171, 0);
    run_frame("air_press",   0, 0, 1, 0, 0, 0, 0,  0,   0,   0,  0,   287, 164, 0);
`ifdef DOUBLE_JUMP_EN
    run_frame("both_walls",  0, 0, 0, 0, 0, 1, 1,  300, 0,   50, 0,   287, 156, 0);
`else
    run_frame("both_walls",  0, 0, 0, 0, 0, 1, 1,  300, 0,   50, 0,   287, 158, 0);
`endif
    run_frame("ceiling",     0, 0, 0, 1, 0, 0, 0,  0,   0,   0,  50,  287, 51,  0);
    run_frame("floor_clamp", 0, 0, 0, 0, 1, 0, 0,  0,   500, 0,  0,   287, 459, 1);
    run_frame("x_clamp0",    0, 1, 0, 0, 0, 0, 1,  5,   0,   0,  0,   0,   459, 1);
    run_frame("left_edge",   1, 0, 0, 0, 0, 0, 0,  0,   0,   0,  0,   0,   459, 1);
    run_frame("right",       0, 1, 0, 0, 0, 0, 0,  0,   0,   0,  0,   2,   459, 1);
    btn_left = 1'b0; btn_right = 1'b0; btn_jump = 1'b0;

    // Second tick while the frame is still waiting on the checker.
    check("ovr:before", int'(overrun), 0);
    s0 = n_start;
    tick_and_wait_start(seen);
    check("ovr:start_seen", int'(seen), 1);
    @(posedge clk); #1 frame_tick = 1'b1;
    @(posedge clk); #1 frame_tick = 1'b0;
    answer_scan(1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0, 0, lat);
    repeat (3) @(posedge clk);
    #1;
    check("ovr:overrun", int'(overrun), 1);
    check("ovr:starts", n_start - s0, 1);
    check("ovr:x", int'(x), 2);

    // Reset while waiting on the checker.
    tick_and_wait_start(seen);
    check("rstwait:start_seen", int'(seen), 1);
    @(posedge clk); #1 reset = 1'b1;
    #1;
    check("rstwait:coll_start", int'(coll_start), 0);
    check("rstwait:x", int'(x), 100);
    check("rstwait:y", int'(y), 100);
    check("rstwait:overrun", int'(overrun), 0);
    check("rstwait:grounded", int'(grounded), 0);
    repeat (2) @(posedge clk);
    #1;
    s0 = n_start;
    r0 = n_redo;
    reset = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("rstwait:redo_pulses", n_redo - r0, 1);
    check("rstwait:starts", n_start - s0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
